// File: rtl/ls_table_scheduler.sv
// rtl/ls_table_scheduler.sv - window/rebuild/bank-swap scheduler for the RAM_Zout table with gated chip readout
// Optional rebuild timeout: define LS_SCHED_TIMEOUT_EN.
module ls_table_scheduler #(
    parameter int w1      = 2**14,
    parameter int w4      = 2**12,
    parameter int pw      = 4,
    parameter int bit_evt = 8
) (
    input  logic               clk_main,
    input  logic               rst,
    input  logic               tstamp_x,
    input  logic               tstamp_z,
    input  logic               build_done,
    output logic               start_build,
    output logic               bank_wr,
    output logic               bank_rd,
    output logic               table_valid,
    output logic               rd_hold,
    output logic               rd_strobe,
    output logic               rd_miss,
    output logic [bit_evt-1:0] evt_snap,
    output logic               timeout_err
);
    localparam int WIN_W = (w1 > 1) ? $clog2(w1) : 1;
    localparam int TO_W  = (w4 > 1) ? $clog2(w4) : 1;
    localparam int RD_W  = (pw > 1) ? $clog2(pw) : 1;

    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(w1 - 1);
    localparam logic [WIN_W-1:0]   WIN_ONE  = WIN_W'(1);
    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(w4 - 1);
    localparam logic [TO_W-1:0]    TO_ONE   = TO_W'(1);
    localparam logic [RD_W-1:0]    RD_LAST  = RD_W'(pw - 1);
    localparam logic [RD_W-1:0]    RD_ONE   = RD_W'(1);
    localparam logic [bit_evt-1:0] EVT_ONE  = bit_evt'(1);
    localparam logic [bit_evt-1:0] EVT_MAX  = {bit_evt{1'b1}};

    typedef enum logic [1:0] {
        S_WIN       = 2'd0,
        S_BUILD     = 2'd1,
        S_SWAP_WAIT = 2'd2
    } state_t;

    state_t             state_q;
    logic               x_prev_q, z_prev_q;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [RD_W-1:0]    rd_cnt_q;
    logic [bit_evt-1:0] evt_cnt_q, evt_cnt_d, evt_snap_q;
    logic               start_build_q, bank_wr_q, table_valid_q;
    logic               rd_hold_q, rd_strobe_q, rd_miss_q;
    logic               x_rise, z_rise, win_end, rd_start, swap;

    assign x_rise   = tstamp_x & ~x_prev_q;
    assign z_rise   = tstamp_z & ~z_prev_q;
    assign win_end  = (state_q == S_WIN) && (win_cnt_q == WIN_LAST);
    assign rd_start = z_rise & table_valid_q & ~rd_hold_q;
    // A readout request always beats a pending swap so the chip never sees the bank flip mid-read.
    assign swap     = (state_q == S_SWAP_WAIT) & ~rd_hold_q & ~z_rise;

    // An edge landing on the window boundary belongs to the new window.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (win_end) begin
            evt_cnt_d = x_rise ? EVT_ONE : '0;
        end else if (x_rise && evt_cnt_q != EVT_MAX) begin
            evt_cnt_d = evt_cnt_q + EVT_ONE;
        end
    end

    always_ff @(posedge clk_main) begin
        if (!rst) begin
            state_q       <= S_WIN;
            x_prev_q      <= 1'b0;
            z_prev_q      <= 1'b0;
            win_cnt_q     <= '0;
            to_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            evt_cnt_q     <= '0;
            evt_snap_q    <= '0;
            start_build_q <= 1'b0;
            bank_wr_q     <= 1'b1;
            table_valid_q <= 1'b0;
            rd_hold_q     <= 1'b0;
            rd_strobe_q   <= 1'b0;
            rd_miss_q     <= 1'b0;
        end else begin
            x_prev_q      <= tstamp_x;
            z_prev_q      <= tstamp_z;
            evt_cnt_q     <= evt_cnt_d;
            start_build_q <= 1'b0;
            rd_strobe_q   <= rd_start;
            rd_miss_q     <= z_rise & ~table_valid_q;
            to_cnt_q      <= (state_q == S_BUILD) ? to_cnt_q + TO_ONE : '0;

            if (rd_start) begin
                rd_hold_q <= 1'b1;
                rd_cnt_q  <= RD_LAST;
            end else if (rd_hold_q) begin
                if (rd_cnt_q == '0) begin
                    rd_hold_q <= 1'b0;
                end else begin
                    rd_cnt_q <= rd_cnt_q - RD_ONE;
                end
            end

            case (state_q)
                S_WIN: begin
                    if (win_end) begin
                        win_cnt_q  <= '0;
                        evt_snap_q <= evt_cnt_q;
                        if (evt_cnt_q != '0) begin
                            start_build_q <= 1'b1;
                            state_q       <= S_BUILD;
                        end
                    end else begin
                        win_cnt_q <= win_cnt_q + WIN_ONE;
                    end
                end
                S_BUILD: begin
                    win_cnt_q <= '0;
                    if (build_done) begin
                        state_q <= S_SWAP_WAIT;
                    end
`ifdef LS_SCHED_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        state_q <= S_WIN;
                    end
`endif
                end
                S_SWAP_WAIT: begin
                    if (swap) begin
                        bank_wr_q     <= ~bank_wr_q;
                        table_valid_q <= 1'b1;
                        state_q       <= S_WIN;
                    end
                end
                default: state_q <= S_WIN;
            endcase
        end
    end

`ifdef LS_SCHED_TIMEOUT_EN
    logic timeout_err_q;

    always_ff @(posedge clk_main) begin
        if (!rst) begin
            timeout_err_q <= 1'b0;
        end else if (state_q == S_BUILD && !build_done && to_cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign start_build = start_build_q;
    assign bank_wr     = bank_wr_q;
    assign bank_rd     = ~bank_wr_q;
    assign table_valid = table_valid_q;
    assign rd_hold     = rd_hold_q;
    assign rd_strobe   = rd_strobe_q;
    assign rd_miss     = rd_miss_q;
    assign evt_snap    = evt_snap_q;

endmodule

// File: tb/tb_ls_table_scheduler.sv
// tb/tb_ls_table_scheduler.sv - directed vector bench for ls_table_scheduler (w1=16, w4=32, pw=4)
module tb_ls_table_scheduler;
`ifdef LS_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk_main = 1'b0;
    logic       rst = 1'b0;
    logic       tstamp_x = 1'b0, tstamp_z = 1'b0, build_done = 1'b0;
    logic       start_build, bank_wr, bank_rd, table_valid;
    logic       rd_hold, rd_strobe, rd_miss, timeout_err;
    logic [7:0] evt_snap;

    int n_vec  = 0;
    int n_fail = 0;

    ls_table_scheduler #(.w1(16), .w4(32), .pw(4), .bit_evt(8)) dut (
        .clk_main(clk_main), .rst(rst), .tstamp_x(tstamp_x), .tstamp_z(tstamp_z),
        .build_done(build_done), .start_build(start_build), .bank_wr(bank_wr),
        .bank_rd(bank_rd), .table_valid(table_valid), .rd_hold(rd_hold),
        .rd_strobe(rd_strobe), .rd_miss(rd_miss), .evt_snap(evt_snap),
        .timeout_err(timeout_err)
    );

    always #5 clk_main = ~clk_main;

    typedef struct {
        int         n;
        bit         rn, x, z, bd;
        bit         sb, bw, tv, rh, rs, rm;
        logic [7:0] snap;
        bit         te;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input bit rn, x, z, bd,
                       input bit sb, bw, tv, rh, rs, rm,
                       input logic [7:0] snap, input bit te);
        vec_t v;
        v.n = n; v.rn = rn; v.x = x; v.z = z; v.bd = bd;
        v.sb = sb; v.bw = bw; v.tv = tv; v.rh = rh; v.rs = rs; v.rm = rm;
        v.snap = snap; v.te = te;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [14:0] act_w, exp_w;
    int          k;

    initial begin
        // n rn x z bd | sb bw tv rh rs rm snap te ; trailing comment = last edge index after reset
        add( 2, 0,0,0,0, 0,1,0,0,0,0, 8'd0, 0);        // reset
        add( 1, 1,1,0,0, 0,1,0,0,0,0, 8'd0, 0);        // e1  x #1
        add( 1, 1,0,0,0, 0,1,0,0,0,0, 8'd0, 0);
        add( 1, 1,1,0,0, 0,1,0,0,0,0, 8'd0, 0);        // e3  x #2
        add( 1, 1,0,0,0, 0,1,0,0,0,0, 8'd0, 0);
        add( 1, 1,1,0,0, 0,1,0,0,0,0, 8'd0, 0);        // e5  x #3
        add( 1, 1,0,1,0, 0,1,0,0,0,1, 8'd0, 0);        // e6  z before swap -> miss
        add( 1, 1,0,1,0, 0,1,0,0,0,0, 8'd0, 0);        // e7  held level, no new miss
        add( 8, 1,0,0,0, 0,1,0,0,0,0, 8'd0, 0);        // e15
        add( 1, 1,0,0,0, 1,1,0,0,0,0, 8'd3, 0);        // e16 start_build, snap 3
        add( 1, 1,0,0,0, 0,1,0,0,0,0, 8'd3, 0);
        add( 3, 1,0,0,0, 0,1,0,0,0,0, 8'd3, 0);        // e20
        add( 1, 1,0,0,1, 0,1,0,0,0,0, 8'd3, 0);        // e21 build_done
        add( 1, 1,0,0,0, 0,0,1,0,0,0, 8'd3, 0);        // e22 swap
        add( 1, 1,0,1,0, 0,0,1,1,1,0, 8'd3, 0);        // e23 readout starts
        add( 1, 1,0,0,0, 0,0,1,1,0,0, 8'd3, 0);
        add( 2, 1,0,0,0, 0,0,1,1,0,0, 8'd3, 0);        // e26 4th hold cycle
        add( 1, 1,0,0,0, 0,0,1,0,0,0, 8'd3, 0);        // e27 hold ends
        add( 1, 1,0,0,1, 0,0,1,0,0,0, 8'd3, 0);        // e28 stray build_done ignored
        add( 9, 1,0,0,0, 0,0,1,0,0,0, 8'd3, 0);        // e37
        add( 1, 1,0,0,0, 0,0,1,0,0,0, 8'd0, 0);        // e38 empty window: snap 0, no start
        add( 1, 1,1,0,0, 0,0,1,0,0,0, 8'd0, 0);        // e39
        add(14, 1,0,0,0, 0,0,1,0,0,0, 8'd0, 0);        // e53
        add( 1, 1,1,0,0, 1,0,1,0,0,0, 8'd1, 0);        // e54 window end; x here counts next window
        add( 1, 1,0,0,0, 0,0,1,0,0,0, 8'd1, 0);
        add( 1, 1,0,1,0, 0,0,1,1,1,0, 8'd1, 0);        // e56 readout
        add( 1, 1,0,0,1, 0,0,1,1,0,0, 8'd1, 0);        // e57 build_done during hold
        add( 1, 1,0,1,0, 0,0,1,1,0,0, 8'd1, 0);        // e58 second z ignored
        add( 1, 1,0,0,0, 0,0,1,1,0,0, 8'd1, 0);
        add( 1, 1,0,0,0, 0,0,1,0,0,0, 8'd1, 0);        // e60 hold falls, not extended
        add( 1, 1,0,0,0, 0,1,1,0,0,0, 8'd1, 0);        // e61 delayed swap
        add(15, 1,0,0,0, 0,1,1,0,0,0, 8'd1, 0);        // e76
        add( 1, 1,0,0,0, 1,1,1,0,0,0, 8'd1, 0);        // e77 carried-over event builds
        add( 1, 1,0,0,1, 0,1,1,0,0,0, 8'd1, 0);        // e78
        add( 1, 1,0,1,0, 0,1,1,1,1,0, 8'd1, 0);        // e79 z and swap coincide: read wins
        add( 3, 1,0,0,0, 0,1,1,1,0,0, 8'd1, 0);
        add( 1, 1,0,0,0, 0,1,1,0,0,0, 8'd1, 0);        // e83
        add( 1, 1,0,0,0, 0,0,1,0,0,0, 8'd1, 0);        // e84 swap
        add( 1, 1,1,0,0, 0,0,1,0,0,0, 8'd1, 0);        // e85
        add(14, 1,0,0,0, 0,0,1,0,0,0, 8'd1, 0);
        add( 1, 1,0,0,0, 1,0,1,0,0,0, 8'd1, 0);        // e100 start_build, no build_done follows
        add(31, 1,0,0,0, 0,0,1,0,0,0, 8'd1, 0);        // e131
        add( 1, 1,0,0,0, 0,0,1,0,0,0, 8'd1, TO_EN);    // e132 timeout
        add( 1, 1,1,0,0, 0,0,1,0,0,0, 8'd1, TO_EN);
        add(14, 1,0,0,0, 0,0,1,0,0,0, 8'd1, TO_EN);
        add( 1, 1,0,0,0, TO_EN,0,1,0,0,0, 8'd1, TO_EN);// e148 window only runs after timeout
        add( 1, 1,0,1,0, 0,0,1,1,1,0, 8'd1, TO_EN);    // e149 readout
        add( 1, 0,0,0,0, 0,1,0,0,0,0, 8'd0, 0);        // e150 reset aborts readout
        add( 1, 1,0,0,1, 0,1,0,0,0,0, 8'd0, 0);        // e151 build_done after reset ignored
        add( 3, 1,0,0,0, 0,1,0,0,0,0, 8'd0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rn; tstamp_x = vecs[i].x; tstamp_z = vecs[i].z; build_done = vecs[i].bd;
            repeat (vecs[i].n) @(posedge clk_main);
            #1;
            act_w = {start_build, bank_wr, bank_rd, table_valid, rd_hold, rd_strobe,
                     rd_miss, evt_snap, timeout_err};
            exp_w = {vecs[i].sb, vecs[i].bw, ~vecs[i].bw, vecs[i].tv, vecs[i].rh,
                     vecs[i].rs, vecs[i].rm, vecs[i].snap, vecs[i].te};
            check($sformatf("vec%0d sb,bw,br,tv,rh,rs,rm,snap,te", i), 32'(act_w), 32'(exp_w));
        end

        // Start-build latency from reset, with a bounded wait.
        rst = 1'b0; tstamp_x = 1'b0; tstamp_z = 1'b0; build_done = 1'b0;
        @(posedge clk_main); #1;
        rst = 1'b1; tstamp_x = 1'b1;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_main); #1;
            tstamp_x = 1'b0;
            if (start_build) begin
                k = c;
                break;
            end
        end
        check("start_build_latency", 32'(k), 32'd16);
        check("evt_snap_single", 32'(evt_snap), 32'd1);
        repeat (4) @(posedge clk_main);
        #1 build_done = 1'b1;
        @(posedge clk_main); #1 build_done = 1'b0;
        check("no_swap_on_done_edge", 32'({bank_wr, table_valid}), 32'b10);
        @(posedge clk_main); #1;
        check("swap_after_done", 32'({bank_wr, bank_rd, table_valid}), 32'b011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
